wb_mem_slave: RTL and testbench

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

---
 rtl/wb_mem_slave_pkg.sv | 25 ++
 rtl/wb_mem_slave_byte_ram.sv | 30 +++
 rtl/wb_mem_slave.sv | 145 ++++++++++++++
 tb/tb_wb_mem_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_slave_pkg.sv
// Wishbone-side definitions shared by the memory slave and its byte RAM.
// Holds the bus widths, the FSM state type and the address window test.
package wb_mem_slave_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // The 34-bit arithmetic keeps base + 4*depth from wrapping at the top of the map.
  function automatic logic addr_in_window(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input int unsigned depth);
    logic [33:0] off;
    logic [33:0] span;
    off  = {2'b00, adr} - {2'b00, base};
    span = {2'b00, depth} << 2;
    return (adr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/wb_mem_slave_byte_ram.sv
// Word storage split into one byte-wide array per lane so each lane's write
// enable maps onto its own RAM column. Synchronous write, combinational read.
module wb_byte_ram
  import wb_mem_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WB_DW-1:0] wdata,
  input  logic [WB_SW-1:0] be,
  input  logic [AW-1:0]    raddr,
  output logic [WB_DW-1:0] rdata
);

  for (genvar gi = 0; gi < WB_SW; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[waddr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave in front of a byte-enabled word memory, with a
// programmable number of wait states and error termination for bad accesses.
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  input  logic [WB_SW-1:0] wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  wb_state_t        state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [AW-1:0]    idx_reg;
  logic [WB_DW-1:0] dat_reg;
  logic [WB_SW-1:0] sel_reg;
  logic             we_reg;
  logic             ok_reg;

  logic             req;
  logic [AW-1:0]    cur_idx;
  logic [WB_DW-1:0] cur_dat;
  logic [WB_SW-1:0] cur_sel;
  logic             cur_we;
  logic             cur_ok;
  logic             ram_we;
  logic [WB_DW-1:0] ram_rdata;

  assign req = wb_cyc_i & wb_stb_i;

  // With zero wait states the write edge is also the acceptance edge, so the
  // live bus is used in IDLE and the latched copy everywhere else.
  assign cur_dat = (state_reg == ST_IDLE) ? wb_dat_i : dat_reg;
  assign cur_sel = (state_reg == ST_IDLE) ? wb_sel_i : sel_reg;
  assign cur_we  = (state_reg == ST_IDLE) ? wb_we_i  : we_reg;
  assign cur_idx = AW'((wb_adr_i - BASE_ADDR) >> 2);
  assign cur_ok  = (state_reg == ST_IDLE)
                 ? (addr_in_window(wb_adr_i, BASE_ADDR, DEPTH_WORDS) && !(wb_we_i && (wb_sel_i == '0)))
                 : ok_reg;

  assign ram_we = !rst && (state_reg != ST_RESP) && (state_next == ST_RESP) && cur_we && cur_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && req) begin
        idx_reg <= cur_idx;
        dat_reg <= wb_dat_i;
        sel_reg <= wb_sel_i;
        we_reg  <= wb_we_i;
        ok_reg  <= cur_ok;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_LOAD == 4'd0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg <= 4'd1) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    wb_dat_o = '0;
    if (state_reg == ST_RESP) begin
      wb_ack_o = ok_reg;
      wb_err_o = !ok_reg;
      if (ok_reg && !we_reg) begin
        wb_dat_o = ram_rdata;
      end
    end
  end

  wb_byte_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_idx_w()),
    .wdata (cur_dat),
    .be    (cur_sel),
    .raddr (idx_reg),
    .rdata (ram_rdata)
  );

  // Write index: live address at acceptance, latched index afterwards.
  function automatic logic [AW-1:0] cur_idx_w();
    return (state_reg == ST_IDLE) ? cur_idx : idx_reg;
  endfunction

endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomised self-checking bench for wb_mem_slave: two instances (1 and 3 wait
// states) checked against a word-array model of the bus-visible behaviour.
module tb_wb_mem_slave;

  localparam int DEPTH0 = 64;
  localparam int DEPTH1 = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] b_adr = '0;
  logic [31:0] b_dat = '0;
  logic [3:0]  b_sel = '0;
  logic        b_we  = 1'b0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
  logic [31:0] dat0, dat1;
  logic        ack0, err0, ack1, err1;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [2][DEPTH0];

  always #5 clk = ~clk;

  wb_mem_slave #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0)
  );

  wb_mem_slave #(.DEPTH_WORDS(DEPTH1), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_cyc_i(cyc1), .wb_stb_i(stb1),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1)
  );

  function automatic int depth_of(input int w);
    return (w != 0) ? DEPTH1 : DEPTH0;
  endfunction

  // Cycle (counted from the acceptance edge) in which the response must appear.
  function automatic int lat_of(input int w);
    return ((w != 0) ? 3 : 1) + 1;
  endfunction

  function automatic bit expect_ok(input int w, input logic we, input logic [31:0] adr, input logic [3:0] sel);
    longint unsigned a;
    a = adr;
    if (a >= longint'(4 * depth_of(w))) return 1'b0;
    if (we && sel == 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_apply(input int w, input logic we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    if (we && expect_ok(w, we, adr, sel)) model[w][adr >> 2] = merge(model[w][adr >> 2], d, sel);
  endtask

  // One complete bus transaction; bus fields are scrambled after acceptance.
  task automatic txn(input int w, input logic we, input logic [31:0] adr, input logic [31:0] d,
                     input logic [3:0] sel, output int ack_at, output int err_at, output int pulses,
                     output logic [31:0] rdat, output bit leak);
    logic a, e;
    logic [31:0] o;
    @(negedge clk);
    b_adr = adr; b_dat = d; b_sel = sel; b_we = we;
    if (w == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end else begin cyc1 = 1'b1; stb1 = 1'b1; end
    @(posedge clk);
    ack_at = -1; err_at = -1; pulses = 0; rdat = '0; leak = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      a = (w == 0) ? ack0 : ack1;
      e = (w == 0) ? err0 : err1;
      o = (w == 0) ? dat0 : dat1;
      if (a) begin if (ack_at < 0) ack_at = k; pulses++; rdat = o; end
      if (e) begin if (err_at < 0) err_at = k; pulses++; if (o !== 32'h0) leak = 1'b1; end
      if (!a && !e && o !== 32'h0) leak = 1'b1;
      if (a || e) begin cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0; end
      b_adr = $urandom; b_dat = $urandom; b_sel = 4'($urandom); b_we = 1'($urandom);
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    $display("txn dut%0d we=%0b adr=%08h dat=%08h sel=%h -> ack@%0d err@%0d rdat=%08h",
             w, we, adr, d, sel, ack_at, err_at, rdat);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ack0, err0, ack1, err1} !== 4'b0 || dat0 !== 32'h0 || dat1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs ack/err=%b dat0=%h dat1=%h want 0", {ack0, err0, ack1, err1}, dat0, dat1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int a_at, e_at, p; logic [31:0] r, v; bit lk;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < depth_of(w); i++) begin
        v = $urandom;
        txn(w, 1'b1, 32'(i * 4), v, 4'hF, a_at, e_at, p, r, lk);
        model_apply(w, 1'b1, 32'(i * 4), v, 4'hF);
        checks++;
        if (a_at != lat_of(w) || e_at != -1 || p != 1) begin
          fails++;
          $display("FAIL fill dut%0d word %0d ack@%0d err@%0d pulses=%0d want ack@%0d", w, i, a_at, e_at, p, lat_of(w));
        end
      end
    end
  endtask

  task automatic test_basic();
    int a_at, e_at, p; logic [31:0] r; bit lk;
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, a_at, e_at, p, r, lk);
    model_apply(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (a_at != 2 || e_at != -1 || p != 1) begin
      fails++; $display("FAIL basic_write ack@%0d err@%0d pulses=%0d want ack@2 only", a_at, e_at, p);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (a_at != 2 || p != 1 || r !== 32'hDEAD_BEEF || lk) begin
      fails++; $display("FAIL basic_read ack@%0d pulses=%0d data=%h leak=%0b want ack@2 DEADBEEF", a_at, p, r, lk);
    end
  endtask

  task automatic test_byte_write();
    int a_at, e_at, p; logic [31:0] r; bit lk;
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, a_at, e_at, p, r, lk);
    model_apply(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    txn(0, 1'b1, 32'h22, 32'h00AA_0000, 4'b0100, a_at, e_at, p, r, lk);
    model_apply(0, 1'b1, 32'h22, 32'h00AA_0000, 4'b0100);
    txn(0, 1'b0, 32'h23, 32'h0, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (a_at != 2 || r !== 32'h11AA_3344) begin
      fails++; $display("FAIL byte_write ack@%0d data=%h want 11aa3344", a_at, r);
    end
  endtask

  task automatic test_out_of_range();
    int a_at, e_at, p; logic [31:0] r; bit lk;
    txn(0, 1'b0, 32'(4 * DEPTH0), 32'h0, 4'hF, a_at, e_at, p, r, lk);
    checks++;
    if (e_at != 2 || a_at != -1 || p != 1 || r !== 32'h0 || lk) begin
      fails++; $display("FAIL oor_read err@%0d ack@%0d pulses=%0d leak=%0b want err@2 only, dat 0", e_at, a_at, p, lk);
    end
    txn(0, 1'b1, 32'(4 * DEPTH0), 32'hCAFE_F00D, 4'hF, a_at, e_at, p, r, lk);
    checks++;
    if (e_at != 2 || a_at != -1 || p != 1) begin
      fails++; $display("FAIL oor_write err@%0d ack@%0d want err@2 only", e_at, a_at);
    end
    txn(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (e_at != 2 || a_at != -1) begin
      fails++; $display("FAIL sel0_write err@%0d ack@%0d want err@2 only", e_at, a_at);
    end
    for (int i = 0; i < DEPTH0; i++) begin
      txn(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, a_at, e_at, p, r, lk);
      checks++;
      if (a_at != 2 || r !== model[0][i]) begin
        fails++; $display("FAIL oor_scan word %0d data=%h want %h", i, r, model[0][i]);
      end
    end
  endtask

  task automatic test_abort();
    int a_at, e_at, p, seen; logic [31:0] r; bit lk;
    @(negedge clk);
    b_adr = 32'h8; b_dat = 32'h55; b_sel = 4'hF; b_we = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc1 = 1'b0; stb1 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++; $display("FAIL abort_resp responses=%0d want 0", seen);
    end
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (a_at != 4 || r !== model[1][2]) begin
      fails++; $display("FAIL abort_data ack@%0d data=%h want ack@4 %h", a_at, r, model[1][2]);
    end
  endtask

  task automatic test_reset_mid();
    int a_at, e_at, p; logic [31:0] r; bit lk;
    @(negedge clk);
    b_adr = 32'h30; b_dat = ~model[0][12]; b_sel = 4'hF; b_we = 1'b1; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack0 !== 1'b0 || err0 !== 1'b0 || dat0 !== 32'h0) begin
      fails++; $display("FAIL rst_wait ack=%b err=%b dat=%h want 0", ack0, err0, dat0);
    end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0; rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (ack0 || err0) begin fails++; $display("FAIL rst_abandon ack=%b err=%b want 0", ack0, err0); end
    end
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (a_at != 2 || r !== model[0][12]) begin
      fails++; $display("FAIL rst_nowrite ack@%0d data=%h want ack@2 %h", a_at, r, model[0][12]);
    end
    @(negedge clk);
    b_adr = 32'h10; b_we = 1'b0; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ack0 !== 1'b1) begin fails++; $display("FAIL rst_pre_ack ack=%b want 1", ack0); end
    rst = 1'b1;
    #1;
    checks++;
    if (ack0 !== 1'b0 || err0 !== 1'b0 || dat0 !== 32'h0) begin
      fails++; $display("FAIL rst_async ack=%b err=%b dat=%h want 0 before edge", ack0, err0, dat0);
    end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0; rst = 1'b0;
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, a_at, e_at, p, r, lk);
    checks++;
    if (a_at != 2 || r !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL rst_recover ack@%0d data=%h want ack@2 deadbeef", a_at, r);
    end
  endtask

  task automatic test_back_to_back();
    int acks, first, second; logic [31:0] d1, d2;
    @(negedge clk);
    b_adr = 32'h0; b_we = 1'b0; b_sel = 4'hF; cyc0 = 1'b1; stb0 = 1'b1;
    acks = 0; first = -1; second = -1; d1 = '0; d2 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        if (first < 0) begin first = k; d1 = dat0; b_adr = 32'h4; end
        else begin second = k; d2 = dat0; cyc0 = 1'b0; stb0 = 1'b0; end
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0;
    checks++;
    if (acks != 2 || first != 2 || second - first < 2 || d1 !== model[0][0] || d2 !== model[0][1]) begin
      fails++;
      $display("FAIL back_to_back acks=%0d at %0d,%0d data %h,%h want 2 acks gap>=2 data %h,%h",
               acks, first, second, d1, d2, model[0][0], model[0][1]);
    end
  endtask

  task automatic test_random();
    int a_at, e_at, p, w; logic [31:0] r, adr, d; logic [3:0] sel; logic we; bit lk, ok;
    for (int n = 0; n < 80; n++) begin
      w   = int'($urandom_range(0, 1));
      we  = 1'($urandom);
      d   = $urandom;
      sel = 4'($urandom);
      adr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * depth_of(w) + 15));
      ok  = expect_ok(w, we, adr, sel);
      txn(w, we, adr, d, sel, a_at, e_at, p, r, lk);
      checks++;
      if (p != 1 || lk || (ok && (a_at != lat_of(w) || e_at != -1)) || (!ok && (e_at != lat_of(w) || a_at != -1))
          || (ok && !we && r !== model[w][adr >> 2])) begin
        fails++;
        $display("FAIL random[%0d] dut%0d we=%0b adr=%h ack@%0d err@%0d data=%h leak=%0b want ok=%0b at %0d data=%h",
                 n, w, we, adr, a_at, e_at, r, lk, ok, lat_of(w), ok ? model[w][adr >> 2] : 32'h0);
      end
      model_apply(w, we, adr, d, sel);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_byte_write();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
